// File: rtl/ram_arbiter.sv
// Arbiter sharing a single-port RAM between the CPU memory path and a debug/loader port.
// Define ARB_RR_EN for round-robin arbitration on ties; the default build gives the CPU fixed priority.
module ram_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              ARB_clk,
   input  logic              ARB_rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              owner
);

   localparam int CNT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t             state_q,      state_d;
   logic               we_q,         we_d;
   logic [CNT_W-1:0]   cnt_q,        cnt_d;
   logic               owner_q,      owner_d;
   logic               last_owner_q, last_owner_d;
   logic [ADDR_W-1:0]  ram_addr_q,   ram_addr_d;
   logic [DATA_W-1:0]  ram_wdata_q,  ram_wdata_d;
   logic               ram_we_q,     ram_we_d;
   logic               ram_re_q,     ram_re_d;
   logic               cpu_ack_q,    cpu_ack_d;
   logic               dbg_ack_q,    dbg_ack_d;
   logic [DATA_W-1:0]  cpu_rdata_q,  cpu_rdata_d;
   logic [DATA_W-1:0]  dbg_rdata_q,  dbg_rdata_d;
   logic               busy_q,       busy_d;
   logic               grant_dbg;

`ifdef ARB_RR_EN
   // On a tie, the requester that was not served last goes next.
   assign grant_dbg = dbg_req && (!cpu_req || !last_owner_q);
`else
   logic unused_last_owner;
   assign grant_dbg         = dbg_req && !cpu_req;
   assign unused_last_owner = last_owner_q;
`endif

   // Outputs are computed from the next state so every output is a flop.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
      state_d      = state_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_we_d     = 1'b0;
      ram_re_d     = 1'b0;
      cpu_ack_d    = 1'b0;
      dbg_ack_d    = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (cpu_req || dbg_req) begin
               owner_d     = grant_dbg;
               we_d        = grant_dbg ? dbg_we    : cpu_we;
               ram_addr_d  = grant_dbg ? dbg_addr  : cpu_addr;
               ram_wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
               ram_we_d    = we_d;
               ram_re_d    = !we_d;
               state_d     = ST_GRANT;
            end
         end

         ST_GRANT: begin
            if (we_q) begin
               cpu_ack_d = !owner_q;
               dbg_ack_d = owner_q;
               state_d   = ST_DONE;
            end else begin
               cnt_d   = CNT_W'(RD_LAT - 1);
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (cnt_q == '0) begin
               if (owner_q) begin
                  dbg_rdata_d = ram_rdata;
               end else begin
                  cpu_rdata_d = ram_rdata;
               end
               cpu_ack_d = !owner_q;
               dbg_ack_d = owner_q;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_DONE: begin
            last_owner_d = owner_q;
            state_d      = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge ARB_clk or posedge ARB_rst) begin
      if (ARB_rst) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         cnt_q        <= '0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         ram_we_q     <= 1'b0;
         ram_re_q     <= 1'b0;
         cpu_ack_q    <= 1'b0;
         dbg_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
         state_q      <= state_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_we_q     <= ram_we_d;
         ram_re_q     <= ram_re_d;
         cpu_ack_q    <= cpu_ack_d;
         dbg_ack_q    <= dbg_ack_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         busy_q       <= busy_d;
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_we    = ram_we_q;
   assign ram_re    = ram_re_q;
   assign busy      = busy_q;
   assign owner     = owner_q;

endmodule
